// File: rtl/puf_pkg.sv
// Shared types and defaults for the arbiter-PUF challenge sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        SAMPLE,
        OUT
    } puf_state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam int          CHAL_W_DEF        = 16;
    localparam int          SETTLE_CYCLES_DEF = 8;
    localparam int          VOTES_DEF         = 5;
    localparam int          WORD_W_DEF        = 32;

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Host and PUF-pin signals of the challenge sequencer.
// Latency: n/a (wiring only).
// Backpressure: resp_valid/resp_ready handshake on the response word.
interface puf_challenge_sequencer_if
    import puf_pkg::*;
#(
    parameter int CHAL_W = CHAL_W_DEF,
    parameter int WORD_W = WORD_W_DEF
);
    logic              start;
    logic [CHAL_W-1:0] seed;
    logic              busy;
    logic [CHAL_W-1:0] challenge;
    logic              pulse;
    logic              response;
    logic [WORD_W-1:0] resp_word;
    logic              resp_valid;
    logic              resp_ready;

    // master: the sequencer itself; slave: host plus PUF pins around it
    modport master (
        input  start, seed, response, resp_ready,
        output busy, challenge, pulse, resp_word, resp_valid
    );

    modport slave (
        output start, seed, response, resp_ready,
        input  busy, challenge, pulse, resp_word, resp_valid
    );
endinterface

// File: rtl/puf_lfsr.sv
// Galois right-shift LFSR producing the challenge sequence; a zero seed becomes 1.
// Latency: load/step take effect on the next clock edge.
// Backpressure: none; advances only when step is asserted.
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int          W    = CHAL_W_DEF,
    parameter logic [W-1:0] TAPS = LFSR_TAPS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] seed,
    output logic [W-1:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? W'(1) : seed;
        end else if (step) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives LFSR challenges and low-high pulses into the arbiter PUF, samples and packs the responses.
// Latency: first resp_valid 1 + WORD_W*V*(2*SETTLE_CYCLES+1) cycles after start (V=VOTES with PUF_MAJORITY_VOTE_EN).
// Backpressure: resp_word/resp_valid hold in OUT until resp_ready; start is ignored while busy.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int CHAL_W        = CHAL_W_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int VOTES         = VOTES_DEF,
    parameter int WORD_W        = WORD_W_DEF
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    puf_challenge_sequencer_if.master bus
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255 || VOTES < 1 || VOTES > 15 ||
        (VOTES % 2) == 0 || WORD_W < 1 || WORD_W > 32) begin : g_param_check
        $error("puf_challenge_sequencer: illegal parameter value");
    end

    puf_state_t        state;
    puf_state_t        next_state;
    logic [7:0]        settle_cnt;
    logic              settle_done;
    logic [BC_W-1:0]   bit_cnt;
    logic              last_bit;
    logic              sync_1;
    logic              sync_2;
    logic              last_vote;
    logic              bit_val;
    logic              lfsr_load;
    logic              lfsr_step;
    logic              pulse_c;
    logic              busy_c;
    logic              valid_c;
    logic [WORD_W-1:0] resp_word;
    logic [CHAL_W-1:0] lfsr_state;

    assign settle_done = (settle_cnt == 8'(SETTLE_CYCLES - 1));
    assign last_bit    = (bit_cnt == BC_W'(WORD_W - 1));

`ifdef PUF_MAJORITY_VOTE_EN
    logic [3:0] vote_cnt;
    logic [3:0] ones_cnt;
    logic [3:0] ones_sum;

    assign ones_sum  = ones_cnt + {3'b000, sync_2};
    assign last_vote = (vote_cnt == 4'(VOTES - 1));
    assign bit_val   = (ones_sum > 4'(VOTES / 2));
`else
    assign last_vote = 1'b1;
    assign bit_val   = sync_2;
`endif

    puf_lfsr #(
        .W    (CHAL_W),
        .TAPS (CHAL_W'(LFSR_TAPS))
    ) u_lfsr (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (bus.seed),
        .state (lfsr_state)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        pulse_c    = 1'b0;
        busy_c     = 1'b1;
        valid_c    = 1'b0;
        unique case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    next_state = ARM;
                    lfsr_load  = 1'b1;
                end
            end
            ARM: begin
                if (settle_done) next_state = FIRE;
            end
            FIRE: begin
                pulse_c = 1'b1;
                if (settle_done) next_state = SAMPLE;
            end
            SAMPLE: begin
                pulse_c = 1'b1;
                // the new challenge lands together with pulse falling, never with it rising
                if (!last_vote) begin
                    next_state = ARM;
                end else if (!last_bit) begin
                    next_state = ARM;
                    lfsr_step  = 1'b1;
                end else begin
                    next_state = OUT;
                end
            end
            OUT: begin
                valid_c = 1'b1;
                if (bus.resp_ready) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            settle_cnt <= '0;
            bit_cnt    <= '0;
            resp_word  <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_cnt   <= '0;
            ones_cnt   <= '0;
`endif
        end else begin
            sync_1 <= bus.response;
            sync_2 <= sync_1;

            if ((state == ARM || state == FIRE) && !settle_done) begin
                settle_cnt <= settle_cnt + 8'd1;
            end else begin
                settle_cnt <= '0;
            end

            if (state == IDLE && bus.start) begin
                resp_word <= '0;
                bit_cnt   <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
                vote_cnt  <= '0;
                ones_cnt  <= '0;
`endif
            end

            if (state == SAMPLE) begin
`ifdef PUF_MAJORITY_VOTE_EN
                if (last_vote) begin
                    vote_cnt <= '0;
                    ones_cnt <= '0;
                end else begin
                    vote_cnt <= vote_cnt + 4'd1;
                    ones_cnt <= ones_sum;
                end
`endif
                if (last_vote) begin
                    resp_word <= resp_word | (WORD_W'(bit_val) << bit_cnt);
                    bit_cnt   <= last_bit ? '0 : bit_cnt + BC_W'(1);
                end
            end
        end
    end

    assign bus.challenge  = lfsr_state;
    assign bus.pulse      = pulse_c;
    assign bus.busy       = busy_c;
    assign bus.resp_valid = valid_c;
    assign bus.resp_word  = resp_word;

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Upstream driver and downstream collector for the arbiter PUF core. On a start request it generates a pseudo-random 16-bit challenge sequence from a seeded LFSR and drives each challenge with a clean low-high excitation pulse. It synchronises and samples the single-bit PUF response, optionally majority-voting repeated evaluations, and packs the resulting bits into a response word. The word is delivered to the host side over a valid/ready handshake. It sits in the user project wrapper between host logic (logic analyser or Wishbone) and the PUF's challenge, pulse and response pins.

## Interface
- CHAL_W, 16, challenge width; fixed to match the PUF core.
- SETTLE_CYCLES, 8, cycles per pulse phase; legal range 3..255.
- VOTES, 5, evaluations per challenge when voting is compiled in; must be odd, 1..15.
- WORD_W, 32, response bits per output word; 1..32.
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- seed  in  CHAL_W  LFSR seed, captured when start is accepted.
- challenge  out  CHAL_W  challenge to the PUF; changes only while pulse is 0.
- pulse  out  1  PUF excitation pulse.
- response  in  1  asynchronous PUF response.
- resp_word  out  WORD_W  packed response bits.
- resp_valid  out  1  resp_word is valid.
- resp_ready  in  1  consumer accepts the word.
- busy  out  1  high from the cycle after start is accepted until the handshake completes.

## Operation
- Reset values: state IDLE, challenge 0, pulse 0, resp_word 0, resp_valid 0, busy 0, synchroniser flops 0, all counters 0.
- States:
  - IDLE: on start, go to ARM. Load the LFSR with seed; a seed of 0 is replaced by 0x0001. challenge is set to the loaded value.
  - ARM: pulse 0 for SETTLE_CYCLES cycles so the arbiter latch clears and the challenge settles. Then go to FIRE.
  - FIRE: pulse 1 for SETTLE_CYCLES cycles. Then go to SAMPLE.
  - SAMPLE: one cycle with pulse still 1. Capture the synchronised response.
    - More votes remaining for this challenge: go to ARM with the same challenge.
    - Otherwise, resolve the bit. If bits remain, step the LFSR, drive the new challenge and go to ARM. If WORD_W bits are complete, go to OUT.
  - OUT: resp_valid 1 and pulse 0. resp_word and resp_valid hold until resp_ready is 1. On the handshake cycle, go to IDLE; resp_valid and busy drop next cycle.
- LFSR: 16-bit Galois form, polynomial x^16+x^14+x^13+x^11+1, tap mask 0xB400.
  - One step per output bit, applied as a right shift with XOR of the mask when the outgoing LSB is 1.
  - The first challenge equals the loaded seed.
- Packing: bit k of the word (evaluation order, starting at 0) goes to resp_word[k]. resp_word is cleared when start is accepted.
- Synchroniser: 2-flop chain on response, clocked continuously. SETTLE_CYCLES≥3 guarantees the FIRE-phase value has reached the sampling flop.
- start while busy or in OUT: ignored. resp_ready outside OUT: ignored.
- A reset asserted mid-operation aborts immediately to the reset values on the next edge; a partial word is discarded.

## Timing
- Cycle 0: start accepted in IDLE.
- Cycle 1: busy=1, state ARM, pulse=0.
- Each evaluation lasts E = 2·SETTLE_CYCLES+1 cycles.
- resp_valid first asserts at cycle 1 + WORD_W·V·E, where V=VOTES with voting compiled in and V=1 without.
- Defaults without voting: 1 + 32·17 = 545. With voting: 1 + 32·5·17 = 2721.
- pulse never rises in the same cycle challenge changes; challenge is stable for at least SETTLE_CYCLES cycles before every pulse rise.

## Configuration
- PUF_MAJORITY_VOTE_EN defined:
  - Each challenge is evaluated VOTES times.
  - A 4-bit ones counter accumulates the samples; the output bit is 1 iff ones > VOTES/2.
  - The counter clears per challenge.
- Not defined: single evaluation per challenge, the bit equals the sample directly, VOTES is ignored and the vote counter is absent.

## Structure
- Package puf_pkg holds:
  - the state enum (IDLE, ARM, FIRE, SAMPLE, OUT);
  - LFSR_TAPS = 16'hB400;
  - CHAL_W_DEF = 16;
  - the default values for SETTLE_CYCLES, VOTES and WORD_W.
- Sub-module puf_lfsr implements the LFSR: load, step, seed-zero substitution and state output.
- The FSM, counters, synchroniser and packer live in the top module.

## Test plan
- Response tied 1, seed 0xACE1, resp_ready 1 → resp_word 0xFFFFFFFF, resp_valid rises exactly at cycle 545 (no voting).
- Response modelled as challenge[0] with 3-cycle delay, seed 0xACE1 → resp_word equals bit 0 of the first 32 reference-LFSR states; challenge is stable across every pulse high window.
- Seed 0 → first challenge 0x0001; response tied 0 → resp_word 0x00000000.
- resp_ready held 0 for 10 cycles in OUT → resp_word and resp_valid stable, pulse 0, a start issued meanwhile is ignored; ready 1 → IDLE, busy 0 the next cycle.
- wb_rst_i pulsed at cycle 200 → next cycle all outputs at reset values; a new start runs a full clean word.
- PUF_MAJORITY_VOTE_EN, VOTES 5, per-challenge sample pattern 1,0,1,1,0 → bit 1; pattern 0,1,0,0,1 → bit 0; resp_valid at cycle 2721.
